// File: rtl/itlb_l0_cache.sv
// Fully-associative, ASID-tagged L0 instruction micro-TLB in front of the main TLB fetch port.
// Optional hit/miss performance counters are enabled by defining ITLB_L0_PERF_CNT_EN.
module itlb_l0_cache #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_vld,
    input  logic [19:0] if_vpn,
    input  logic [9:0]  if_asid,
    output logic        if_rdy,
    output logic        if_rsp_vld,
    output logic [19:0] if_ppn,
    output logic        if_fault,
    input  logic        flush,
    output logic        tlb_lookup_vld,
    output logic [19:0] tlb_lookup_vpn,
    input  logic        tlb_hit,
    input  logic [19:0] tlb_ppn,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned VPN_W  = 20;
    localparam int unsigned ASID_W = 10;
    localparam int unsigned PPN_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q  [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_q  [ENTRIES];
    logic [IDX_W-1:0]   ptr_q;

    logic [VPN_W-1:0]   req_vpn_q;
    logic [ASID_W-1:0]  req_asid_q;
    logic               rsp_vld_q;
    logic               rsp_hit_q;
    logic [PPN_W-1:0]   rsp_ppn_q;
    logic               rsp_fault_q;

    logic               hit_c;
    logic [PPN_W-1:0]   hit_ppn_c;
    logic [IDX_W-1:0]   victim_c;
    logic               free_c;
    logic               accept_c;
    logic               walk_c;
    logic               fill_c;

    // Associative match against the live request; tags are unique so no priority is needed
    always_comb begin
        hit_c     = 1'b0;
        hit_ppn_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i] && (vpn_q[i] == if_vpn) && (asid_q[i] == if_asid)) begin
                hit_c     = 1'b1;
                hit_ppn_c = ppn_q[i];
            end
        end
    end

    // Prefer the lowest free slot; fall back to the round-robin pointer when full
    always_comb begin
        victim_c = ptr_q;
        free_c   = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim_c = IDX_W'(i);
                free_c   = 1'b1;
            end
        end
    end

    assign if_rdy         = (state_q == IDLE) && !flush && !rst;
    assign accept_c       = if_req_vld && if_rdy;
    assign walk_c         = (state_q == WALK);
    assign fill_c         = walk_c && tlb_hit && !flush;
    assign tlb_lookup_vld = walk_c && !rst;
    assign tlb_lookup_vpn = req_vpn_q;
    assign if_rsp_vld     = rsp_vld_q && !flush;
    assign if_ppn         = rsp_ppn_q;
    assign if_fault       = rsp_fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c && !hit_c) state_d = WALK;
            WALK:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Control, response and miss-latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            ptr_q       <= '0;
            req_vpn_q   <= '0;
            req_asid_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_ppn_q   <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            rsp_hit_q <= 1'b0;
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (accept_c) begin
                    if (hit_c) begin
                        rsp_vld_q   <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_ppn_q   <= hit_ppn_c;
                        rsp_fault_q <= 1'b0;
                    end else begin
                        req_vpn_q  <= if_vpn;
                        req_asid_q <= if_asid;
                    end
                end
                if (walk_c) begin
                    rsp_vld_q <= 1'b1;
                    if (tlb_hit) begin
                        valid_q[victim_c] <= 1'b1;
                        rsp_ppn_q         <= tlb_ppn;
                        rsp_fault_q       <= 1'b0;
                        if (!free_c) ptr_q <= ptr_q + IDX_W'(1);
                    end else begin
                        rsp_ppn_q   <= '0;
                        rsp_fault_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Entry payload storage; qualified by the valid bits so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && fill_c) begin
            vpn_q[victim_c]  <= req_vpn_q;
            asid_q[victim_c] <= req_asid_q;
            ppn_q[victim_c]  <= tlb_ppn;
        end
    end

`ifdef ITLB_L0_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Hits count when the response is actually delivered; misses count per surviving walk
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rsp_hit_q && !flush) hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (walk_c && !flush)    miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_itlb_l0_cache.sv
// Directed bench for itlb_l0_cache: transaction-level L0 model plus per-cycle output comparison.
module tb_itlb_l0_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_vld;
    logic [19:0] if_vpn;
    logic [9:0]  if_asid;
    logic        if_rdy;
    logic        if_rsp_vld;
    logic [19:0] if_ppn;
    logic        if_fault;
    logic        flush;
    logic        tlb_lookup_vld;
    logic [19:0] tlb_lookup_vpn;
    logic        tlb_hit;
    logic [19:0] tlb_ppn;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    itlb_l0_cache dut (
        .clk(clk), .rst(rst),
        .if_req_vld(if_req_vld), .if_vpn(if_vpn), .if_asid(if_asid), .if_rdy(if_rdy),
        .if_rsp_vld(if_rsp_vld), .if_ppn(if_ppn), .if_fault(if_fault),
        .flush(flush),
        .tlb_lookup_vld(tlb_lookup_vld), .tlb_lookup_vpn(tlb_lookup_vpn),
        .tlb_hit(tlb_hit), .tlb_ppn(tlb_ppn),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the L0 contents and counters
    logic        m_v    [4];
    logic [19:0] m_vpn  [4];
    logic [9:0]  m_asid [4];
    logic [19:0] m_ppn  [4];
    int          m_ptr  = 0;
    int          m_hits = 0;
    int          m_miss = 0;

    // Expected outputs for the current cycle, and a hit response pending for the next one
    logic        chk_en = 1'b0;
    logic        exp_rdy, exp_rsp, exp_fault, exp_lkv;
    logic [19:0] exp_ppn, exp_lkvpn;
    logic        c_vld = 1'b0;
    logic [19:0] c_ppn = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("if_rdy", 32'(if_rdy), 32'(exp_rdy));
            check("if_rsp_vld", 32'(if_rsp_vld), 32'(exp_rsp));
            check("tlb_lookup_vld", 32'(tlb_lookup_vld), 32'(exp_lkv));
            if (exp_rsp) begin
                check("if_ppn", 32'(if_ppn), 32'(exp_ppn));
                check("if_fault", 32'(if_fault), 32'(exp_fault));
            end
            if (exp_lkv) check("tlb_lookup_vpn", 32'(tlb_lookup_vpn), 32'(exp_lkvpn));
        end
    end

    function automatic logic m_lookup(input logic [19:0] vpn, input logic [9:0] asid,
                                      output logic [19:0] ppn);
        ppn = '0;
        for (int i = 0; i < 4; i++)
            if (m_v[i] && m_vpn[i] == vpn && m_asid[i] == asid) begin
                ppn = m_ppn[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic m_fill(input logic [19:0] vpn, input logic [9:0] asid, input logic [19:0] ppn);
        int slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_v[i]) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
        end
        m_v[slot] = 1'b1; m_vpn[slot] = vpn; m_asid[slot] = asid; m_ppn[slot] = ppn;
    endtask

    // Start a new cycle: idle inputs, deliver any pending hit response unless flushed
    task automatic next_cycle(input logic fl);
        @(posedge clk);
        #1;
        chk_en     = 1'b1;
        if_req_vld = 1'b0;
        flush      = fl;
        tlb_hit    = 1'b0;
        tlb_ppn    = '0;
        exp_rsp    = c_vld && !fl;
        exp_ppn    = c_ppn;
        exp_fault  = 1'b0;
        if (exp_rsp) m_hits++;
        c_vld      = 1'b0;
        exp_rdy    = !fl;
        exp_lkv    = 1'b0;
        exp_lkvpn  = '0;
        if (fl) for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    endtask

    // One translation; main TLB answers th/tp if the L0 misses
    task automatic req(input logic [19:0] vpn, input logic [9:0] asid,
                       input logic th, input logic [19:0] tp);
        logic [19:0] p;
        logic        h;
        next_cycle(1'b0);
        if_req_vld = 1'b1; if_vpn = vpn; if_asid = asid;
        h = m_lookup(vpn, asid, p);
        if (h) begin
            c_vld = 1'b1;
            c_ppn = p;
            return;
        end
        next_cycle(1'b0);
        exp_rdy = 1'b0; exp_lkv = 1'b1; exp_lkvpn = vpn;
        tlb_hit = th; tlb_ppn = tp;
        if_vpn  = 20'hFFFFF;
        m_miss++;
        if (th) m_fill(vpn, asid, tp);
        next_cycle(1'b0);
        exp_rdy = 1'b0; exp_rsp = 1'b1; exp_ppn = th ? tp : 20'h0; exp_fault = !th;
    endtask

    // Miss whose walk cycle is hit by flush
    task automatic walk_flush(input logic [19:0] vpn, input logic [9:0] asid);
        next_cycle(1'b0);
        if_req_vld = 1'b1; if_vpn = vpn; if_asid = asid;
        next_cycle(1'b1);
        exp_lkv = 1'b1; exp_lkvpn = vpn;
        tlb_hit = 1'b1; tlb_ppn = 20'h5A5A5;
        next_cycle(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        rst = 1'b1; if_req_vld = 1'b0; if_vpn = '0; if_asid = '0;
        flush = 1'b0; tlb_hit = 1'b0; tlb_ppn = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_rdy", 32'(if_rdy), 32'd0);
        check("rst_rsp", 32'(if_rsp_vld), 32'd0);
        check("rst_ppn", 32'(if_ppn), 32'd0);
        check("rst_fault", 32'(if_fault), 32'd0);
        check("rst_lkv", 32'(tlb_lookup_vld), 32'd0);
        check("rst_lkvpn", 32'(tlb_lookup_vpn), 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;

        // Cold miss then back-to-back hits
        req(20'h12345, 10'd3, 1'b1, 20'hABCDE);
        check("t1_ppn", 32'(if_ppn), 32'h000ABCDE);
        req(20'h12345, 10'd3, 1'b0, 20'h0);
        req(20'h12345, 10'd3, 1'b0, 20'h0);
        req(20'h12345, 10'd3, 1'b0, 20'h0);
        next_cycle(1'b0);
        check("t2_ppn", 32'(if_ppn), 32'h000ABCDE);

        // Main-TLB miss faults and is never cached
        req(20'h00077, 10'd3, 1'b0, 20'h0);
        check("t3_fault", 32'(if_fault), 32'd1);
        req(20'h00077, 10'd3, 1'b0, 20'h0);
        next_cycle(1'b0);

        // Replacement after a clean flush
        next_cycle(1'b1);
        req(20'h01000, 10'd3, 1'b1, 20'h10000);
        req(20'h02000, 10'd3, 1'b1, 20'h20000);
        req(20'h03000, 10'd3, 1'b1, 20'h30000);
        req(20'h04000, 10'd3, 1'b1, 20'h40000);
        req(20'h05000, 10'd3, 1'b1, 20'h50000);
        check("t4_model_ptr", 32'(m_ptr), 32'd1);
        check("t4_model_e0", 32'(m_vpn[0]), 32'h00005000);
        req(20'h02000, 10'd3, 1'b0, 20'h0);
        req(20'h01000, 10'd3, 1'b1, 20'h11111);
        check("t4_refill_ppn", 32'(if_ppn), 32'h00011111);

        // ASID isolation
        req(20'h00100, 10'd3, 1'b1, 20'h11100);
        req(20'h00100, 10'd4, 1'b1, 20'h22222);
        check("t5_asid4_ppn", 32'(if_ppn), 32'h00022222);
        req(20'h00100, 10'd3, 1'b0, 20'h0);
        next_cycle(1'b0);
        check("t5_asid3_ppn", 32'(if_ppn), 32'h00011100);

        // Flush kills a pending hit pulse
        req(20'h00100, 10'd4, 1'b0, 20'h0);
        next_cycle(1'b1);

        // Flush during a walk, then earlier hits must walk again
        walk_flush(20'h0ABCD, 10'd3);
        req(20'h0ABCD, 10'd3, 1'b1, 20'h0BBBB);
        req(20'h00100, 10'd3, 1'b1, 20'h33333);
        check("t6_rewalk_ppn", 32'(if_ppn), 32'h00033333);
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk_en = 1'b0;

`ifdef ITLB_L0_PERF_CNT_EN
        check("hit_cnt", hit_cnt, 32'(m_hits));
        check("miss_cnt", miss_cnt, 32'(m_miss));
`else
        check("hit_cnt_off", hit_cnt, 32'd0);
        check("miss_cnt_off", miss_cnt, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
